ecc_scrub_ctrl: RTL and testbench
=================================

Name: ecc_scrub_ctrl

Overview:
- Background ECC scrubber for the std cache data/tag SRAM.
- Walks every set index, reads all ASSOC ways through the shared SRAM port, and inspects the per-way error flags from the external Hsiao correction stage.
- Writes corrected lines back for ways with single-bit errors; reports uncorrectable ways.
- Competes with the cache controller for the SRAM port; the cache always has priority through an external grant.

Parameters:
- NUM_SETS, 256, number of set indices swept; must be a power of two, at least 2.
- ASSOC, 8, ways read per set access.
- SCRUB_INTERVAL, 1024, idle cycles between consecutive set scrubs; 0 means back-to-back.
- CNT_W, 16, width of the saturating event counters.
- line_t, std_cache_pkg::cache_line_SRAM_t, stored line type (ECC-encoded data, tag, dirty, valid).

Ports:
- clk_i, in, 1, clock.
- rst_ni, in, 1, asynchronous active-low reset.
- enable_i, in, 1, scrubbing enabled.
- sram_req_o, in/out: out, 1, SRAM access request.
- sram_gnt_i, in, 1, grant from the cache/scrubber port arbiter.
- sram_we_o, out, ASSOC, per-way write enable; all zero means read.
- sram_idx_o, out, $clog2(NUM_SETS), set index.
- sram_wdata_o, out, ASSOC x line_t, write-back lines.
- corr_data_i, in, ASSOC x line_t, corrected lines from the correction stage.
- err_i, in, ASSOC x 2, per-way error flags: bit0 = corrected single error, bit1 = uncorrectable. Already zero for invalid lines.
- cache_wr_i, in, 1, cache controller writes the SRAM this cycle.
- cache_wr_idx_i, in, $clog2(NUM_SETS), index of that cache write.
- corr_cnt_o, out, CNT_W, count of corrected ways.
- uncorr_cnt_o, out, CNT_W, count of uncorrectable ways.
- uncorr_o, out, 1, one-cycle pulse on an uncorrectable detection.
- uncorr_idx_o, out, $clog2(NUM_SETS), index of the last uncorrectable set.
- uncorr_way_o, out, ASSOC, way mask of the last uncorrectable set.
- sweep_done_o, out, 1, one-cycle pulse when the index wraps.

Behaviour:
- Interface: one clock `clk_i`; reset `rst_ni` is asynchronous and active-low.
- Reset values: all outputs 0, index 0, state IDLE, interval timer loaded with SCRUB_INTERVAL.
- IDLE: the timer decrements only while enable_i=1. At 0 (or immediately if SCRUB_INTERVAL=0) go to READ. If enable_i=0, hold the timer.
- READ: sram_req_o=1, sram_we_o=0, sram_idx_o=index.
  - Request held until sram_gnt_i; inputs are stable while waiting.
  - Grant moves to CHECK.
  - If enable_i drops before grant, drop the request and return to IDLE; index is unchanged.
- CHECK: corr_data_i and err_i are valid exactly one cycle after the granted read and are sampled here.
  - fix mask = ways with bit0=1 and bit1=0.
  - bad mask = ways with bit1=1.
  - Capture corr_data_i into the write buffer.
  - bad mask nonzero: pulse uncorr_o, load uncorr_idx_o and uncorr_way_o, add popcount(bad) to uncorr_cnt_o.
  - fix mask nonzero: go to WRITE. Otherwise go to NEXT.
- WRITE: sram_req_o=1, sram_we_o=fix mask, sram_wdata_o=buffer. Bad ways are never written.
  - On grant, add popcount(fix) to corr_cnt_o and go to NEXT.
- Collision: cache_wr_i=1 with cache_wr_idx_i==index while in CHECK or in WRITE before grant.
  - Discard the buffer, add nothing to corr_cnt_o, return to READ for the same index.
  - uncorr reporting from the aborted CHECK still occurs.
  - A grant and a collision in the same WRITE cycle count as a completed write.
- NEXT: index increments by 1, reload the timer, go to IDLE.
  - Wrap from NUM_SETS-1 to 0 pulses sweep_done_o.
- Counters saturate at all-ones and never wrap. An add that would overflow clamps.
- rst_ni assertion mid-access aborts immediately with no completion.

Decomposition:
- ecc_scrub_pkg holds:
  - the state enum (IDLE, READ, CHECK, WRITE, NEXT);
  - error-bit constants ERR_CORR=0 and ERR_UNCORR=1;
  - the saturating-add function.
- The popcount is inline.
- One natural sub-module: ecc_scrub_timer, the loadable down-counter with zero flag.

Test Plan:
- Clean sweep: NUM_SETS=4, SCRUB_INTERVAL=2, gnt always 1, err_i=0 -> 4 reads to idx 0,1,2,3 with no writes; sweep_done_o pulses once when idx returns to 0; counters stay 0.
- Correctable: err_i way2 = 2'b01 at idx 1 -> WRITE with sram_we_o=8'b0000_0100 and wdata way2 equal to corr_data_i way2; corr_cnt_o=1.
- Mixed: way0 = 01, way5 = 10 -> write mask 8'b0000_0001; uncorr_o pulses once with uncorr_way_o=8'b0010_0000 and uncorr_idx_o=index; both counters equal 1.
- Arbitration: gnt low for 5 cycles during READ and during WRITE -> request, index, and wdata held stable; exactly one access per grant.
- Collision: cache_wr_i with matching idx in CHECK -> no write, READ reissued for the same idx, corr_cnt_o unchanged. Non-matching idx -> write proceeds.
- Saturation and reset: with CNT_W=2 and 5 corrections -> corr_cnt_o=3. rst_ni low during WRITE -> sram_req_o=0 immediately and idx=0 after release.

Source files
------------

// File: rtl/ecc_scrub_pkg.sv
// Shared types, constants and helpers for the background ECC scrubber.
package ecc_scrub_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCheck,
        StWrite,
        StNext
    } scrub_state_e;

    localparam int unsigned ERR_CORR   = 0;
    localparam int unsigned ERR_UNCORR = 1;

    // Stand-in for the cache's stored line type; override via the line_t type parameter.
    typedef struct packed {
        logic [31:0] data;
        logic [11:0] tag;
        logic        dirty;
        logic        valid;
    } scrub_line_t;

    // Add b to a, clamping at the all-ones value of a w-bit counter (w <= 31).
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned w);
        logic [32:0] sum;
        logic [32:0] max;
        sum = {1'b0, a} + {1'b0, b};
        max = (33'd1 << w) - 33'd1;
        return (sum > max) ? max[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/ecc_scrub_timer.sv
// Loadable down-counter pacing set scrubs; holds at zero and flags it.
module ecc_scrub_timer #(
    parameter int unsigned Load = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int unsigned W = (Load > 0) ? $clog2(Load + 1) : 1;

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = W'(Load);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= W'(Load);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ecc_scrub_ctrl.sv
// Background scrubber: reads each set through the shared SRAM port, writes back
// single-bit-corrected ways and reports uncorrectable ones.
module ecc_scrub_ctrl
    import ecc_scrub_pkg::*;
#(
    parameter int unsigned NUM_SETS       = 256,
    parameter int unsigned ASSOC          = 8,
    parameter int unsigned SCRUB_INTERVAL = 1024,
    parameter int unsigned CNT_W          = 16,
    parameter type         line_t         = scrub_line_t,
    localparam int unsigned IdxW          = $clog2(NUM_SETS)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        enable_i,
    output logic                        sram_req_o,
    input  logic                        sram_gnt_i,
    output logic [ASSOC-1:0]            sram_we_o,
    output logic [IdxW-1:0]             sram_idx_o,
    output line_t [ASSOC-1:0]           sram_wdata_o,
    input  line_t [ASSOC-1:0]           corr_data_i,
    input  logic [ASSOC-1:0][1:0]       err_i,
    input  logic                        cache_wr_i,
    input  logic [IdxW-1:0]             cache_wr_idx_i,
    output logic [CNT_W-1:0]            corr_cnt_o,
    output logic [CNT_W-1:0]            uncorr_cnt_o,
    output logic                        uncorr_o,
    output logic [IdxW-1:0]             uncorr_idx_o,
    output logic [ASSOC-1:0]            uncorr_way_o,
    output logic                        sweep_done_o
);

    localparam int unsigned PopW = $clog2(ASSOC + 1);

    scrub_state_e             state_q, state_d;
    logic [IdxW-1:0]          idx_q, idx_d;
    line_t [ASSOC-1:0]        buf_q, buf_d;
    logic [ASSOC-1:0]         fix_q, fix_d;
    logic [CNT_W-1:0]         corr_cnt_q, corr_cnt_d;
    logic [CNT_W-1:0]         uncorr_cnt_q, uncorr_cnt_d;
    logic                     uncorr_q, uncorr_d;
    logic [IdxW-1:0]          uncorr_idx_q, uncorr_idx_d;
    logic [ASSOC-1:0]         uncorr_way_q, uncorr_way_d;
    logic                     sweep_q, sweep_d;

    logic                     timer_load, timer_dec, timer_zero;
    logic [ASSOC-1:0]         fix_mask, bad_mask;
    logic [PopW-1:0]          bad_pop, fix_pop;
    logic                     collide;

    ecc_scrub_timer #(
        .Load (SCRUB_INTERVAL)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .load_i (timer_load),
        .dec_i  (timer_dec),
        .zero_o (timer_zero)
    );

    always_comb begin
        fix_mask = '0;
        bad_mask = '0;
        bad_pop  = '0;
        fix_pop  = '0;
        for (int w = 0; w < int'(ASSOC); w++) begin
            fix_mask[w] = err_i[w][ERR_CORR] & ~err_i[w][ERR_UNCORR];
            bad_mask[w] = err_i[w][ERR_UNCORR];
            bad_pop     = bad_pop + PopW'(bad_mask[w]);
            fix_pop     = fix_pop + PopW'(fix_q[w]);
        end
    end

    assign collide = cache_wr_i && (cache_wr_idx_i == idx_q);

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        buf_d        = buf_q;
        fix_d        = fix_q;
        corr_cnt_d   = corr_cnt_q;
        uncorr_cnt_d = uncorr_cnt_q;
        uncorr_d     = 1'b0;
        uncorr_idx_d = uncorr_idx_q;
        uncorr_way_d = uncorr_way_q;
        sweep_d      = 1'b0;
        timer_load   = 1'b0;
        timer_dec    = 1'b0;
        sram_req_o   = 1'b0;
        sram_we_o    = '0;

        unique case (state_q)
            StIdle: begin
                if (enable_i) begin
                    if (timer_zero) begin
                        state_d = StRead;
                    end else begin
                        timer_dec = 1'b1;
                    end
                end
            end
            StRead: begin
                sram_req_o = enable_i;
                if (!enable_i) begin
                    state_d = StIdle;
                end else if (sram_gnt_i) begin
                    state_d = StCheck;
                end
            end
            StCheck: begin
                buf_d = corr_data_i;
                fix_d = fix_mask;
                if (bad_mask != '0) begin
                    uncorr_d     = 1'b1;
                    uncorr_idx_d = idx_q;
                    uncorr_way_d = bad_mask;
                    uncorr_cnt_d = CNT_W'(sat_add(32'(uncorr_cnt_q), 32'(bad_pop), CNT_W));
                end
                if (collide) begin
                    fix_d   = '0;
                    state_d = StRead;
                end else if (fix_mask != '0) begin
                    state_d = StWrite;
                end else begin
                    state_d = StNext;
                end
            end
            StWrite: begin
                sram_req_o = 1'b1;
                sram_we_o  = fix_q;
                // A grant wins over a same-cycle collision: the write already happened.
                if (sram_gnt_i) begin
                    corr_cnt_d = CNT_W'(sat_add(32'(corr_cnt_q), 32'(fix_pop), CNT_W));
                    state_d    = StNext;
                end else if (collide) begin
                    fix_d   = '0;
                    state_d = StRead;
                end
            end
            StNext: begin
                idx_d      = idx_q + IdxW'(1);
                sweep_d    = (idx_q == IdxW'(NUM_SETS - 1));
                timer_load = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            buf_q        <= '0;
            fix_q        <= '0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
            uncorr_q     <= 1'b0;
            uncorr_idx_q <= '0;
            uncorr_way_q <= '0;
            sweep_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            buf_q        <= buf_d;
            fix_q        <= fix_d;
            corr_cnt_q   <= corr_cnt_d;
            uncorr_cnt_q <= uncorr_cnt_d;
            uncorr_q     <= uncorr_d;
            uncorr_idx_q <= uncorr_idx_d;
            uncorr_way_q <= uncorr_way_d;
            sweep_q      <= sweep_d;
        end
    end

    assign sram_idx_o   = idx_q;
    assign sram_wdata_o = buf_q;
    assign corr_cnt_o   = corr_cnt_q;
    assign uncorr_cnt_o = uncorr_cnt_q;
    assign uncorr_o     = uncorr_q;
    assign uncorr_idx_o = uncorr_idx_q;
    assign uncorr_way_o = uncorr_way_q;
    assign sweep_done_o = sweep_q;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// Directed bench for ecc_scrub_ctrl: 4 sets, 8 ways, interval 2, 2-bit counters.
module tb_ecc_scrub_ctrl;
    import ecc_scrub_pkg::*;

    logic                   clk;
    logic                   rst_n;
    logic                   enable;
    logic                   sram_req;
    logic                   gnt;
    logic [7:0]             sram_we;
    logic [1:0]             sram_idx;
    scrub_line_t [7:0]      sram_wdata;
    scrub_line_t [7:0]      corr_data;
    logic [7:0][1:0]        err;
    logic                   cache_wr;
    logic [1:0]             cache_wr_idx;
    logic [1:0]             corr_cnt;
    logic [1:0]             uncorr_cnt;
    logic                   uncorr;
    logic [1:0]             uncorr_idx;
    logic [7:0]             uncorr_way;
    logic                   sweep_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0][1:0]        err_tab  [4];
    scrub_line_t [7:0]      data_tab [4];

    // Bus monitor / SRAM read-data model
    int                     rd_count, wr_count, uncorr_pulses, sweep_pulses;
    logic [1:0]             rd_log [16];
    logic [7:0]             last_we;
    logic [1:0]             last_wr_idx;
    scrub_line_t [7:0]      last_wdata;

    ecc_scrub_ctrl #(
        .NUM_SETS       (4),
        .ASSOC          (8),
        .SCRUB_INTERVAL (2),
        .CNT_W          (2)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .enable_i       (enable),
        .sram_req_o     (sram_req),
        .sram_gnt_i     (gnt),
        .sram_we_o      (sram_we),
        .sram_idx_o     (sram_idx),
        .sram_wdata_o   (sram_wdata),
        .corr_data_i    (corr_data),
        .err_i          (err),
        .cache_wr_i     (cache_wr),
        .cache_wr_idx_i (cache_wr_idx),
        .corr_cnt_o     (corr_cnt),
        .uncorr_cnt_o   (uncorr_cnt),
        .uncorr_o       (uncorr),
        .uncorr_idx_o   (uncorr_idx),
        .uncorr_way_o   (uncorr_way),
        .sweep_done_o   (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count      <= 0;
            wr_count      <= 0;
            uncorr_pulses <= 0;
            sweep_pulses  <= 0;
            last_we       <= '0;
            last_wr_idx   <= '0;
            last_wdata    <= '0;
            err           <= '0;
            corr_data     <= '0;
        end else begin
            err       <= '0;
            corr_data <= '0;
            if (sram_req && gnt && sram_we == '0) begin
                if (rd_count < 16) rd_log[rd_count] <= sram_idx;
                rd_count  <= rd_count + 1;
                err       <= err_tab[sram_idx];
                corr_data <= data_tab[sram_idx];
            end
            if (sram_req && gnt && sram_we != '0) begin
                wr_count    <= wr_count + 1;
                last_we     <= sram_we;
                last_wr_idx <= sram_idx;
                last_wdata  <= sram_wdata;
            end
            if (uncorr) uncorr_pulses <= uncorr_pulses + 1;
            if (sweep_done) sweep_pulses <= sweep_pulses + 1;
        end
    end

    task automatic do_reset();
        rst_n        = 1'b0;
        enable       = 1'b0;
        gnt          = 1'b1;
        cache_wr     = 1'b0;
        cache_wr_idx = '0;
        for (int s = 0; s < 4; s++) err_tab[s] = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (sram_req !== 1'b0 || sram_we !== 8'h00 || sram_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_bus: req=%0b we=%0h idx=%0d, want 0/0/0", sram_req, sram_we,
                     sram_idx);
        end
        n_checks++;
        if (corr_cnt !== 2'd0 || uncorr_cnt !== 2'd0 || uncorr !== 1'b0 ||
            uncorr_idx !== 2'd0 || uncorr_way !== 8'h00 || sweep_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_status: cc=%0d uc=%0d u=%0b ui=%0d uw=%0h sd=%0b, want all 0",
                     corr_cnt, uncorr_cnt, uncorr, uncorr_idx, uncorr_way, sweep_done);
        end
        n_checks++;
        if (sram_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_wdata: got %0h want 0", sram_wdata);
        end
    endtask

    task automatic test_clean_sweep();
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 200 && sweep_pulses == 0; i++) @(negedge clk);
        n_checks++;
        if (sweep_pulses != 1) begin
            n_fail++;
            $display("FAIL sweep_pulse: got %0d want 1", sweep_pulses);
        end
        n_checks++;
        if (rd_count != 4 || wr_count != 0) begin
            n_fail++;
            $display("FAIL sweep_counts: reads=%0d writes=%0d want 4/0", rd_count, wr_count);
        end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (rd_log[k] !== 2'(k)) begin
                n_fail++;
                $display("FAIL sweep_order[%0d]: got %0d want %0d", k, rd_log[k], k);
            end
        end
        n_checks++;
        if (sram_idx !== 2'd0 || corr_cnt !== 2'd0 || uncorr_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL sweep_end: idx=%0d cc=%0d uc=%0d want 0/0/0", sram_idx, corr_cnt,
                     uncorr_cnt);
        end
        // sweep_done must be a single-cycle pulse
        repeat (3) @(negedge clk);
        n_checks++;
        if (sweep_pulses != 1) begin
            n_fail++;
            $display("FAIL sweep_single: got %0d pulses want 1", sweep_pulses);
        end
    endtask

    task automatic test_correctable();
        do_reset();
        err_tab[1][2] = 2'b01;
        enable = 1'b1;
        for (int i = 0; i < 200 && wr_count == 0; i++) @(negedge clk);
        n_checks++;
        if (wr_count != 1 || last_we !== 8'b0000_0100 || last_wr_idx !== 2'd1) begin
            n_fail++;
            $display("FAIL corr_write: n=%0d we=%b idx=%0d want 1/00000100/1", wr_count,
                     last_we, last_wr_idx);
        end
        n_checks++;
        if (last_wdata[2] !== data_tab[1][2]) begin
            n_fail++;
            $display("FAIL corr_wdata: got %0h want %0h", last_wdata[2], data_tab[1][2]);
        end
        n_checks++;
        if (corr_cnt !== 2'd1 || uncorr_cnt !== 2'd0 || uncorr_pulses != 0) begin
            n_fail++;
            $display("FAIL corr_cnt: cc=%0d uc=%0d up=%0d want 1/0/0", corr_cnt, uncorr_cnt,
                     uncorr_pulses);
        end
    endtask

    task automatic test_mixed();
        do_reset();
        err_tab[2][0] = 2'b01;
        err_tab[2][5] = 2'b10;
        enable = 1'b1;
        for (int i = 0; i < 200 && wr_count == 0; i++) @(negedge clk);
        n_checks++;
        if (last_we !== 8'b0000_0001 || last_wr_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL mixed_we: we=%b idx=%0d want 00000001/2", last_we, last_wr_idx);
        end
        n_checks++;
        if (uncorr_pulses != 1 || uncorr_way !== 8'b0010_0000 || uncorr_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL mixed_uncorr: pulses=%0d way=%b idx=%0d want 1/00100000/2",
                     uncorr_pulses, uncorr_way, uncorr_idx);
        end
        n_checks++;
        if (corr_cnt !== 2'd1 || uncorr_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL mixed_cnt: cc=%0d uc=%0d want 1/1", corr_cnt, uncorr_cnt);
        end
    endtask

    task automatic test_arbitration();
        do_reset();
        err_tab[0][3] = 2'b01;
        gnt    = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 50 && !sram_req; i++) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (sram_req !== 1'b1 || sram_we !== 8'h00 || sram_idx !== 2'd0 || rd_count != 0) begin
                n_fail++;
                $display("FAIL arb_read_hold[%0d]: req=%0b we=%0h idx=%0d rd=%0d want 1/0/0/0",
                         c, sram_req, sram_we, sram_idx, rd_count);
            end
            @(negedge clk);
        end
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        for (int i = 0; i < 20 && sram_we == '0; i++) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (sram_req !== 1'b1 || sram_we !== 8'b0000_1000 || sram_idx !== 2'd0 ||
                sram_wdata[3] !== data_tab[0][3] || wr_count != 0 || rd_count != 1) begin
                n_fail++;
                $display("FAIL arb_write_hold[%0d]: req=%0b we=%b idx=%0d wr=%0d rd=%0d", c,
                         sram_req, sram_we, sram_idx, wr_count, rd_count);
            end
            @(negedge clk);
        end
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (wr_count != 1 || rd_count != 1 || corr_cnt !== 2'd1 || sram_idx !== 2'd1) begin
            n_fail++;
            $display("FAIL arb_once: wr=%0d rd=%0d cc=%0d idx=%0d want 1/1/1/1", wr_count,
                     rd_count, corr_cnt, sram_idx);
        end
        gnt = 1'b1;
    endtask

    task automatic test_collision();
        do_reset();
        err_tab[1][4] = 2'b01;
        err_tab[2][6] = 2'b01;
        enable = 1'b1;
        for (int i = 0; i < 200 && rd_count < 2; i++) @(negedge clk);
        cache_wr     = 1'b1;
        cache_wr_idx = 2'd1;
        @(negedge clk);
        cache_wr = 1'b0;
        n_checks++;
        if (sram_req !== 1'b1 || sram_we !== 8'h00 || sram_idx !== 2'd1 || corr_cnt !== 2'd0) begin
            n_fail++;
            $display("FAIL coll_reissue: req=%0b we=%0h idx=%0d cc=%0d want 1/0/1/0", sram_req,
                     sram_we, sram_idx, corr_cnt);
        end
        for (int i = 0; i < 50 && wr_count == 0; i++) @(negedge clk);
        n_checks++;
        if (rd_count != 3 || rd_log[2] !== 2'd1 || last_wr_idx !== 2'd1 ||
            last_we !== 8'b0001_0000 || corr_cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL coll_retry: rd=%0d idx=%0d we=%b cc=%0d want 3/1/00010000/1",
                     rd_count, last_wr_idx, last_we, corr_cnt);
        end
        for (int i = 0; i < 200 && rd_count < 4; i++) @(negedge clk);
        cache_wr     = 1'b1;
        cache_wr_idx = 2'd3;
        @(negedge clk);
        cache_wr = 1'b0;
        for (int i = 0; i < 50 && wr_count < 2; i++) @(negedge clk);
        n_checks++;
        if (wr_count != 2 || rd_count != 4 || last_wr_idx !== 2'd2 ||
            last_we !== 8'b0100_0000 || corr_cnt !== 2'd2) begin
            n_fail++;
            $display("FAIL coll_nomatch: wr=%0d rd=%0d idx=%0d we=%b cc=%0d want 2/4/2/01000000/2",
                     wr_count, rd_count, last_wr_idx, last_we, corr_cnt);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        err_tab[0][0] = 2'b01;
        err_tab[0][1] = 2'b01;
        err_tab[0][2] = 2'b01;
        err_tab[1][0] = 2'b01;
        err_tab[1][1] = 2'b01;
        for (int w = 4; w < 8; w++) err_tab[2][w] = 2'b10;
        enable = 1'b1;
        for (int i = 0; i < 200 && wr_count < 1; i++) @(negedge clk);
        n_checks++;
        if (corr_cnt !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_first: got %0d want 3", corr_cnt);
        end
        for (int i = 0; i < 200 && wr_count < 2; i++) @(negedge clk);
        n_checks++;
        if (corr_cnt !== 2'd3) begin
            n_fail++;
            $display("FAIL sat_corr: got %0d want 3", corr_cnt);
        end
        for (int i = 0; i < 200 && rd_count < 3; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        n_checks++;
        if (uncorr_cnt !== 2'd3 || uncorr_way !== 8'hF0) begin
            n_fail++;
            $display("FAIL sat_uncorr: cnt=%0d way=%0h want 3/f0", uncorr_cnt, uncorr_way);
        end
    endtask

    task automatic test_reset_mid_write();
        do_reset();
        err_tab[0][1] = 2'b01;
        gnt    = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 50 && !sram_req; i++) @(negedge clk);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        for (int i = 0; i < 20 && sram_we == '0; i++) @(negedge clk);
        n_checks++;
        if (sram_we !== 8'b0000_0010) begin
            n_fail++;
            $display("FAIL rst_pre: we=%b want 00000010", sram_we);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (sram_req !== 1'b0 || sram_we !== 8'h00) begin
            n_fail++;
            $display("FAIL rst_abort: req=%0b we=%0h want 0/0", sram_req, sram_we);
        end
        @(negedge clk);
        rst_n = 1'b1;
        gnt   = 1'b1;
        #1;
        n_checks++;
        if (sram_idx !== 2'd0 || corr_cnt !== 2'd0 || wr_count != 0) begin
            n_fail++;
            $display("FAIL rst_after: idx=%0d cc=%0d wr=%0d want 0/0/0", sram_idx, corr_cnt,
                     wr_count);
        end
    endtask

    initial begin
        for (int s = 0; s < 4; s++) begin
            for (int w = 0; w < 8; w++) begin
                data_tab[s][w].data  = 32'hA5C3_0000 | (32'(s) << 8) | 32'(w);
                data_tab[s][w].tag   = 12'h100 + 12'(s * 8 + w);
                data_tab[s][w].dirty = w[0];
                data_tab[s][w].valid = 1'b1;
            end
        end
        test_reset();
        test_clean_sweep();
        test_correctable();
        test_mixed();
        test_arbitration();
        test_collision();
        test_saturation();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
